fetch_mem_ctrl: RTL and testbench
=================================

Name: fetch_mem_ctrl

Overview:
- Initiator side of the synchronous RAM interface: the CPU-side controller that drives RAM address, write enable and write data, and consumes the RAM's one-cycle-latency registered read data.
- Owns the program counter and instruction register.
- Sequences instruction fetch, dispatches each instruction to the execution core by valid/ready handshake, and serves the core's load/store requests.
- Sits between the RAM and the datapath/decoder in the top level.

Parameters:
- DATA_W, 16, RAM word width; width of ir, mem_din, mem_dout, dwdata, drdata.
- ADDR_W, 9, RAM address width; width of pc, mem_addr, daddr.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr  out  ADDR_W  RAM read/write address.
- mem_write  out  1  RAM write enable.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM registered read data; valid the cycle after mem_addr is sampled.
- ir  out  DATA_W  instruction register.
- ir_valid  out  1  ir holds an undispatched instruction.
- ir_ready  in  1  core accepts ir.
- exec_done  in  1  core finished current instruction.
- halt  in  1  core requests stop.
- dreq  in  1  data access request.
- dwe  in  1  1 = store, 0 = load.
- daddr  in  ADDR_W  data address.
- dwdata  in  DATA_W  store data.
- dack  out  1  one-cycle access-complete pulse.
- drdata  out  DATA_W  load data.
- pc  out  ADDR_W  program counter, which holds the address of the next fetch.
- halted  out  1  controller stopped.

Behaviour:
- States: IF1, IF2, DISPATCH, EXEC, DWR, DRD1, DRD2, DACK, HALT. All outputs except registers are Moore, decoded from state.
- Reset: at the rising edge with reset=1, the following values load.
  - state=IF1, pc=0, ir=0, drdata=0.
  - Latched addr/data registers are cleared to 0.
  - reset overrides every other input and any state.
- Default drives: mem_write=0 and mem_din=latched wdata in every state except DWR. mem_addr=pc in fetch/dispatch/exec states.
- IF1: mem_addr=pc → IF2.
- IF2: mem_addr=pc; ir<=mem_dout; pc<=pc+1 modulo 2^ADDR_W (all-ones wraps to 0) → DISPATCH.
- DISPATCH: ir_valid=1 (only here). If ir_ready → EXEC, else hold. ir is stable while ir_valid=1.
- EXEC: priority halt > dreq > exec_done.
  - halt → HALT.
  - dreq: latch daddr into addr_l and dwdata into wdata_l. dwe=1 → DWR; dwe=0 → DRD1.
  - exec_done → IF1.
  - Otherwise stay in EXEC.
- DWR: mem_addr=addr_l, mem_write=1, mem_din=wdata_l, dack=1 → EXEC. The RAM commits the write at the closing edge of DWR.
- DRD1: mem_addr=addr_l → DRD2.
- DRD2: mem_addr=addr_l; drdata<=mem_dout → DACK.
- DACK: dack=1; drdata valid → EXEC. drdata holds until the next load completes.
- Latency: dreq sampled at edge n.
  - Store: dack in cycle n+1.
  - Load: dack and valid drdata in cycle n+3.
  - Fetch: ir_valid rises 2 cycles after entering IF1.
- Handshake rules:
  - dreq/dwe/daddr/dwdata are sampled only in EXEC. Changes in other states are ignored.
  - The core deasserts dreq in the dack cycle. dreq still high on return to EXEC is a new request.
  - ir_ready outside DISPATCH, and exec_done/halt outside EXEC, are ignored.
- HALT: halted=1, mem_write=0, pc/ir frozen. Leaves only via reset.
- Reset mid-operation:
  - Reset asserted during DWR: the write at that edge still occurs, since mem_write was 1 in that cycle.
  - Reset in DRD1/DRD2: the load is abandoned with no dack.
  - The cycle after any reset edge has mem_write=0.
- mem_write=1 only in DWR. dack is never high for 2 consecutive cycles.

Test Plan:
- Preload mem[0]=16'h1234, mem[1]=16'hABCD; release reset, hold ir_ready=1, pulse exec_done in EXEC → ir_valid in cycle 2 with ir=1234, pc=1; second dispatch ir=ABCD, pc=2.
- In EXEC, dreq=1, dwe=1, daddr=9'h0F0, dwdata=16'h5A5A → next cycle mem_write=1, mem_addr=0F0, mem_din=5A5A, dack=1. Then dreq dwe=0 to 0F0 → dack 3 cycles after sampling, drdata=5A5A.
- Hold ir_ready=0 for 5 cycles in DISPATCH → ir_valid stays 1, ir unchanged, pc unchanged. Assert ir_ready → EXEC next cycle.
- Force pc to 9'h1FF (preload, fetch sequence) → after IF2 pc=0. Next fetch reads mem[0].
- Assert halt and dreq together in EXEC → HALT, no dack, halted=1 indefinitely, mem_write=0. Assert reset → next cycle state IF1, pc=0, halted=0.
- Assert reset during DRD2 → no dack ever issued, drdata=0, fetch restarts from address 0.

Source files
------------

// File: rtl/fetch_mem_ctrl_if.sv
// Bus between the fetch/memory controller, the synchronous RAM and the
// execution core. master = controller side, slave = RAM + core side.
interface fetch_mem_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9
);
   // RAM side
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write;
   logic [DATA_W-1:0] mem_din;
   logic [DATA_W-1:0] mem_dout;
   // instruction dispatch
   logic [DATA_W-1:0] ir;
   logic              ir_valid;
   logic              ir_ready;
   logic              exec_done;
   logic              halt;
   // core data access
   logic              dreq;
   logic              dwe;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dwdata;
   logic              dack;
   logic [DATA_W-1:0] drdata;
   // status
   logic [ADDR_W-1:0] pc;
   logic              halted;

   modport master (
      output mem_addr, mem_write, mem_din, ir, ir_valid, dack, drdata, pc, halted,
      input  mem_dout, ir_ready, exec_done, halt, dreq, dwe, daddr, dwdata
   );

   modport slave (
      input  mem_addr, mem_write, mem_din, ir, ir_valid, dack, drdata, pc, halted,
      output mem_dout, ir_ready, exec_done, halt, dreq, dwe, daddr, dwdata
   );
endinterface

// File: rtl/fetch_mem_ctrl.sv
// CPU-side RAM initiator: owns pc/ir, fetches and dispatches instructions,
// and serves the core's load/store requests over a one-cycle-latency RAM.
module fetch_mem_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 9
) (
   input logic              clk,
   input logic              reset,
   fetch_mem_ctrl_if.master bus
);

   typedef enum logic [3:0] {
      IF1, IF2, DISPATCH, EXEC, DWR, DRD1, DRD2, DACK, HALT
   } state_t;

   // data request captured in EXEC so the core may change its drives later
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } dreq_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc_q;
   logic [DATA_W-1:0] ir_q;
   logic [DATA_W-1:0] drdata_q;
   dreq_t             req_l;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IF1;
      else       state <= state_nxt;
   end

   // next-state: halt outranks a data request, which outranks exec_done
   always_comb begin
      state_nxt = state;
      case (state)
         IF1:      state_nxt = IF2;
         IF2:      state_nxt = DISPATCH;
         DISPATCH: if (bus.ir_ready) state_nxt = EXEC;
         EXEC: begin
            if (bus.halt)           state_nxt = HALT;
            else if (bus.dreq)      state_nxt = bus.dwe ? DWR : DRD1;
            else if (bus.exec_done) state_nxt = IF1;
         end
         DWR:      state_nxt = EXEC;
         DRD1:     state_nxt = DRD2;
         DRD2:     state_nxt = DACK;
         DACK:     state_nxt = EXEC;
         HALT:     state_nxt = HALT;
         default:  state_nxt = IF1;
      endcase
   end

   // Moore outputs decoded from state
   always_comb begin
      bus.mem_addr  = pc_q;
      bus.mem_write = 1'b0;
      bus.mem_din   = req_l.wdata;
      bus.ir_valid  = 1'b0;
      bus.dack      = 1'b0;
      bus.halted    = 1'b0;
      case (state)
         DISPATCH: bus.ir_valid = 1'b1;
         DWR: begin
            bus.mem_addr  = req_l.addr;
            bus.mem_write = 1'b1;
            bus.dack      = 1'b1;
         end
         DRD1, DRD2: bus.mem_addr = req_l.addr;
         DACK: begin
            bus.mem_addr = req_l.addr;
            bus.dack     = 1'b1;
         end
         HALT:    bus.halted = 1'b1;
         default: ;
      endcase
   end

   // pc/ir/drdata/request latches; RAM data is consumed one cycle after its address
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= '0;
         ir_q     <= '0;
         drdata_q <= '0;
         req_l    <= '0;
      end else begin
         if (state == IF2) begin
            ir_q <= bus.mem_dout;
            pc_q <= pc_q + 1'b1;
         end
         if (state == EXEC && !bus.halt && bus.dreq) begin
            req_l.addr  <= bus.daddr;
            req_l.wdata <= bus.dwdata;
         end
         if (state == DRD2) drdata_q <= bus.mem_dout;
      end
   end

   assign bus.pc     = pc_q;
   assign bus.ir     = ir_q;
   assign bus.drdata = drdata_q;

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Directed bench for fetch_mem_ctrl with a behavioural one-cycle-latency RAM.
module tb_fetch_mem_ctrl;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 9;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   fetch_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   fetch_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // synchronous RAM: write at the edge, registered read data
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_din;
      bus.mem_dout <= mem[bus.mem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // step at least once, until ir_valid or budget exhausted
   task automatic wait_dispatch(input string tag, input int maxc);
      int n;
      step();
      n = 1;
      while (!bus.ir_valid && n < maxc) begin
         step();
         n++;
      end
      chk(tag, {31'd0, bus.ir_valid}, 32'd1);
   endtask

   initial begin
      int n;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'hC000 | 16'(i);
      mem[0] = 16'h1234;
      mem[1] = 16'hABCD;
      bus.mem_dout  = '0;
      bus.ir_ready  = 1'b1;
      bus.exec_done = 1'b0;
      bus.halt      = 1'b0;
      bus.dreq      = 1'b0;
      bus.dwe       = 1'b0;
      bus.daddr     = '0;
      bus.dwdata    = '0;
      reset         = 1'b1;
      step();
      step();
      // reset state
      chk("rst_pc",       32'(bus.pc), 32'h0);
      chk("rst_ir",       32'(bus.ir), 32'h0);
      chk("rst_drdata",   32'(bus.drdata), 32'h0);
      chk("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
      chk("rst_halted",   32'(bus.halted), 32'h0);
      chk("rst_mem_wr",   32'(bus.mem_write), 32'h0);
      chk("rst_dack",     32'(bus.dack), 32'h0);

      // first fetch: IF1 now, ir_valid two cycles later
      reset = 1'b0;
      step();
      chk("if2_ir_valid", 32'(bus.ir_valid), 32'h0);
      step();
      chk("f0_ir_valid", 32'(bus.ir_valid), 32'h1);
      chk("f0_ir",       32'(bus.ir), 32'h1234);
      chk("f0_pc",       32'(bus.pc), 32'h1);
      step();                                   // EXEC
      chk("exec_ir_valid", 32'(bus.ir_valid), 32'h0);
      bus.exec_done = 1'b1;
      step();                                   // IF1
      bus.exec_done = 1'b0;
      step();                                   // IF2
      step();                                   // DISPATCH
      chk("f1_ir_valid", 32'(bus.ir_valid), 32'h1);
      chk("f1_ir",       32'(bus.ir), 32'hABCD);
      chk("f1_pc",       32'(bus.pc), 32'h2);
      step();                                   // EXEC

      // store to 0x0F0
      bus.dreq = 1'b1; bus.dwe = 1'b1; bus.daddr = 9'h0F0; bus.dwdata = 16'h5A5A;
      step();                                   // DWR
      chk("st_mem_write", 32'(bus.mem_write), 32'h1);
      chk("st_mem_addr",  32'(bus.mem_addr), 32'h0F0);
      chk("st_mem_din",   32'(bus.mem_din), 32'h5A5A);
      chk("st_dack",      32'(bus.dack), 32'h1);
      bus.dreq = 1'b0; bus.dwdata = 16'h0000;
      step();                                   // EXEC
      chk("st_dack_low",  32'(bus.dack), 32'h0);
      chk("st_wr_low",    32'(bus.mem_write), 32'h0);
      chk("st_ram",       32'(mem[9'h0F0]), 32'h5A5A);

      // load from 0x0F0: dack three cycles after sampling
      bus.dreq = 1'b1; bus.dwe = 1'b0; bus.daddr = 9'h0F0;
      step();                                   // DRD1
      chk("ld_addr",  32'(bus.mem_addr), 32'h0F0);
      chk("ld_dack1", 32'(bus.dack), 32'h0);
      bus.dreq = 1'b0; bus.daddr = 9'h000;
      step();                                   // DRD2
      chk("ld_dack2", 32'(bus.dack), 32'h0);
      step();                                   // DACK
      chk("ld_dack",   32'(bus.dack), 32'h1);
      chk("ld_drdata", 32'(bus.drdata), 32'h5A5A);
      chk("ld_wr",     32'(bus.mem_write), 32'h0);
      step();                                   // EXEC
      chk("ld_dack_low", 32'(bus.dack), 32'h0);
      chk("ld_hold",     32'(bus.drdata), 32'h5A5A);

      // dispatch stall with ir_ready low
      bus.ir_ready  = 1'b0;
      bus.exec_done = 1'b1;
      step();                                   // IF1
      bus.exec_done = 1'b0;
      step();                                   // IF2
      step();                                   // DISPATCH
      for (int i = 0; i < 5; i++) begin
         chk("stall_ir_valid", 32'(bus.ir_valid), 32'h1);
         chk("stall_ir",       32'(bus.ir), 32'hC002);
         chk("stall_pc",       32'(bus.pc), 32'h3);
         step();
      end
      chk("stall_still", 32'(bus.ir_valid), 32'h1);
      bus.ir_ready = 1'b1;
      step();                                   // EXEC
      chk("stall_release", 32'(bus.ir_valid), 32'h0);
      chk("exec_mem_addr", 32'(bus.mem_addr), 32'h3);

      // run fetches until pc reaches 0x1FF, then check wrap to 0
      bus.exec_done = 1'b1;
      n = 0;
      while (!(bus.ir_valid && bus.pc == 9'h1FF) && n < 3000) begin
         step();
         n++;
      end
      chk("wrap_reach", 32'(bus.pc), 32'h1FF);
      chk("wrap_ir1fe", 32'(bus.ir), 32'hC1FE);
      wait_dispatch("wrap_to1", 10);
      chk("wrap_pc0",   32'(bus.pc), 32'h0);
      chk("wrap_ir1ff", 32'(bus.ir), 32'hC1FF);
      wait_dispatch("wrap_to2", 10);
      chk("wrap_pc1",   32'(bus.pc), 32'h1);
      chk("wrap_ir0",   32'(bus.ir), 32'h1234);

      // halt wins over a simultaneous store request
      bus.exec_done = 1'b0;
      step();                                   // EXEC
      bus.halt = 1'b1; bus.dreq = 1'b1; bus.dwe = 1'b1;
      bus.daddr = 9'h010; bus.dwdata = 16'hFFFF;
      step();                                   // HALT
      bus.halt = 1'b0; bus.dreq = 1'b0; bus.exec_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("halt_halted", 32'(bus.halted), 32'h1);
         chk("halt_dack",   32'(bus.dack), 32'h0);
         chk("halt_wr",     32'(bus.mem_write), 32'h0);
         chk("halt_pc",     32'(bus.pc), 32'h1);
         step();
      end
      chk("halt_no_store", 32'(mem[9'h010]), 32'hC010);
      bus.exec_done = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("unhalt_halted", 32'(bus.halted), 32'h0);
      chk("unhalt_pc",     32'(bus.pc), 32'h0);
      chk("unhalt_wr",     32'(bus.mem_write), 32'h0);
      step();                                   // IF2
      step();                                   // DISPATCH
      chk("unhalt_ir", 32'(bus.ir), 32'h1234);
      step();                                   // EXEC

      // reset during DRD2 abandons the load
      bus.dreq = 1'b1; bus.dwe = 1'b0; bus.daddr = 9'h0F0;
      step();                                   // DRD1
      bus.dreq = 1'b0;
      step();                                   // DRD2
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_drdata", 32'(bus.drdata), 32'h0);
      chk("abort_dack",   32'(bus.dack), 32'h0);
      chk("abort_pc",     32'(bus.pc), 32'h0);
      chk("abort_wr",     32'(bus.mem_write), 32'h0);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("abort_no_dack", 32'(bus.dack), 32'h0);
         if (i == 1) begin
            chk("abort_ir", 32'(bus.ir), 32'h1234);
            chk("abort_pc1", 32'(bus.pc), 32'h1);
         end
      end
      chk("abort_drdata_end", 32'(bus.drdata), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
